// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file and its
// busy scoreboard.
package regfile_pkg;

    localparam int DEFAULT_DATA_W   = 32;
    localparam int DEFAULT_NUM_REGS = 32;
    localparam int WR_PORTS         = 2;

    // Ceiling log2, used to derive the register address width.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << result) < value) begin
                result = result + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bitmap: set at issue, cleared at writeback, bulk-cleared
// on flush, with same-cycle writeback clears forwarded to the read ports.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int ADDR_W   = clog2(NUM_REGS),
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [WR_PORTS-1:0]          wr_en,
    input  logic [WR_PORTS*ADDR_W-1:0]   wr_addr,
    input  logic                         issue_en,
    input  logic [ADDR_W-1:0]            issue_addr,
    input  logic                         flush,
    input  logic [NUM_RD*ADDR_W-1:0]     rd_addr,
    output logic [NUM_RD-1:0]            rd_busy,
    output logic [NUM_REGS-1:0]          busy_vec
);

    localparam logic [NUM_REGS-1:0] ONE_HOT0  = NUM_REGS'(1);
    localparam logic [NUM_REGS-1:0] LIVE_MASK = (ZERO_REG != 0) ? ~ONE_HOT0 : '1;

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] set_hot;
    logic [NUM_REGS-1:0] clr_hot;
    logic [NUM_REGS-1:0] busy_d;

    // Flush beats issue, issue beats a writeback clear on the same register.
    always_comb begin
        // NOTE: every variable gets a default at the top of the block so no
        // path leaves it unassigned, which would otherwise infer a latch.
        set_hot = issue_en ? (ONE_HOT0 << issue_addr) : '0;
        clr_hot = '0;
        for (int p = 0; p < WR_PORTS; p++) begin
            if (wr_en[p]) begin
                clr_hot = clr_hot | (ONE_HOT0 << wr_addr[p*ADDR_W +: ADDR_W]);
            end
        end
        busy_d = flush ? '0 : ((set_hot | (busy_q & ~clr_hot)) & LIVE_MASK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_busy
        logic [ADDR_W-1:0] ra;
        assign ra         = rd_addr[i*ADDR_W +: ADDR_W];
        assign rd_busy[i] = busy_q[ra] & ~clr_hot[ra] & ~((ZERO_REG != 0) && (ra == '0));
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp_bypass.sv
// Two-write, NUM_RD-read register file with same-cycle write-to-read bypass
// and a busy scoreboard for the hazard unit.
module regfile_mp_bypass
    import regfile_pkg::*;
#(
    parameter int  DATA_W   = DEFAULT_DATA_W,
    parameter int  NUM_REGS = DEFAULT_NUM_REGS,
    parameter int  NUM_RD   = 2,
    parameter int  ZERO_REG = 1,
    localparam int ADDR_W   = clog2(NUM_REGS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [WR_PORTS-1:0]          wr_en,
    input  logic [WR_PORTS*ADDR_W-1:0]   wr_addr,
    input  logic [WR_PORTS*DATA_W-1:0]   wr_data,
    input  logic [NUM_RD*ADDR_W-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0]     rd_data,
    output logic [NUM_RD-1:0]            rd_busy,
    input  logic                         issue_en,
    input  logic [ADDR_W-1:0]            issue_addr,
    input  logic                         flush,
    output logic [NUM_REGS-1:0]          busy_vec
);

    logic [ADDR_W-1:0]   wa    [WR_PORTS];
    logic [DATA_W-1:0]   wd    [WR_PORTS];
    logic [WR_PORTS-1:0] wr_ok;
    logic [DATA_W-1:0]   regs  [NUM_REGS];

    for (genvar p = 0; p < WR_PORTS; p++) begin : g_wr_unpack
        assign wa[p]    = wr_addr[p*ADDR_W +: ADDR_W];
        assign wd[p]    = wr_data[p*DATA_W +: DATA_W];
        assign wr_ok[p] = wr_en[p] & ~((ZERO_REG != 0) && (wa[p] == '0));
    end

    // Ports are applied in ascending order, so port 1 wins an address clash.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the array is reset because reads must return zero straight
            // out of reset; this keeps it in flops rather than a RAM macro.
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int p = 0; p < WR_PORTS; p++) begin
                if (wr_ok[p]) begin
                    regs[wa[p]] <= wd[p];
                end
            end
        end
    end

    // Bypass scans ports in the same order as the write, so the forwarded
    // value always equals what will be stored after the edge.
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd_val;

        assign ra = rd_addr[i*ADDR_W +: ADDR_W];

        always_comb begin
            rd_val = regs[ra];
            for (int p = 0; p < WR_PORTS; p++) begin
                if (wr_en[p] && (wa[p] == ra)) begin
                    rd_val = wd[p];
                end
            end
            if ((ZERO_REG != 0) && (ra == '0)) begin
                rd_val = '0;
            end
        end

        assign rd_data[i*DATA_W +: DATA_W] = rd_val;
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .flush      (flush),
        .rd_addr    (rd_addr),
        .rd_busy    (rd_busy),
        .busy_vec   (busy_vec)
    );

endmodule

// File: tb/tb_regfile_mp_bypass.sv
// Scoreboard bench for regfile_mp_bypass: directed scenarios followed by
// random traffic, checked against an array-based reference model.
module tb_regfile_mp_bypass;

    logic        clk;
    logic        rst_n;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        issue_en;
    logic [4:0]  issue_addr;
    logic        flush;
    logic [31:0] busy_vec;

    regfile_mp_bypass #(
        .DATA_W   (32),
        .NUM_REGS (32),
        .NUM_RD   (2),
        .ZERO_REG (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .flush      (flush),
        .busy_vec   (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  b;
        logic [31:0] bv;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit   [31:0] mem [32];
    bit   [31:0] busy_m;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, req);
        end
    endtask

    function automatic bit [31:0] exp_rd(input bit [4:0] ra, input bit [1:0] we,
                                         input bit [4:0] wa0, input bit [31:0] wd0,
                                         input bit [4:0] wa1, input bit [31:0] wd1);
        if (ra == 0) return 32'd0;
        if (we[1] && wa1 == ra) return wd1;
        if (we[0] && wa0 == ra) return wd0;
        return mem[ra];
    endfunction

    function automatic bit exp_busy(input bit [4:0] ra, input bit [1:0] we,
                                    input bit [4:0] wa0, input bit [4:0] wa1);
        if (ra == 0) return 1'b0;
        if ((we[0] && wa0 == ra) || (we[1] && wa1 == ra)) return 1'b0;
        return busy_m[ra];
    endfunction

    // Drive one cycle of stimulus, queue the expected response, then retire
    // the cycle's effect into the model after the edge.
    task automatic step(input string tag, input bit rst, input bit [1:0] we,
                        input bit [4:0] wa0, input bit [31:0] wd0,
                        input bit [4:0] wa1, input bit [31:0] wd1,
                        input bit [4:0] ra0, input bit [4:0] ra1,
                        input bit ie, input bit [4:0] ia, input bit fl);
        exp_t e;
        rst_n      = ~rst;
        wr_en      = we;
        wr_addr    = {wa1, wa0};
        wr_data    = {wd1, wd0};
        rd_addr    = {ra1, ra0};
        issue_en   = ie;
        issue_addr = ia;
        flush      = fl;
        if (rst) begin
            for (int r = 0; r < 32; r++) mem[r] = 32'd0;
            busy_m = 32'd0;
        end
        e.tag = tag;
        e.d0  = exp_rd(ra0, we, wa0, wd0, wa1, wd1);
        e.d1  = exp_rd(ra1, we, wa0, wd0, wa1, wd1);
        e.b   = {exp_busy(ra1, we, wa0, wa1), exp_busy(ra0, we, wa0, wa1)};
        e.bv  = busy_m;
        exp_q.push_back(e);
        @(posedge clk);
        if (!rst) begin
            if (fl) begin
                busy_m = 32'd0;
            end else begin
                if (we[0]) busy_m[wa0] = 1'b0;
                if (we[1]) busy_m[wa1] = 1'b0;
                if (ie && ia != 0) busy_m[ia] = 1'b1;
            end
            if (we[0] && wa0 != 0) mem[wa0] = wd0;
            if (we[1] && wa1 != 0) mem[wa1] = wd1;
        end
        #1;
    endtask

    task automatic rd(input string tag, input bit [4:0] ra0, input bit [4:0] ra1);
        step(tag, 1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, ra0, ra1, 1'b0, 5'd0, 1'b0);
    endtask

    function automatic bit [4:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    // Monitor: outputs are combinational and valid every cycle, so compare
    // one queued expectation per falling edge.
    initial begin : monitor
        exp_t m;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                m = exp_q.pop_front();
                check({m.tag, ".rd0"},  rd_data[31:0],  m.d0);
                check({m.tag, ".rd1"},  rd_data[63:32], m.d1);
                check({m.tag, ".busy"}, {30'd0, rd_busy}, {30'd0, m.b});
                check({m.tag, ".bvec"}, busy_vec, m.bv);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin : driver
        bit        r_rst;
        bit [1:0]  r_we;
        bit [4:0]  r_wa0, r_wa1, r_ra0, r_ra1, r_ia;
        bit [31:0] r_wd0, r_wd1;
        bit        r_ie, r_fl;

        rst_n = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        issue_en = 1'b0; issue_addr = '0; flush = 1'b0;
        busy_m = 32'd0;
        for (int r = 0; r < 32; r++) mem[r] = 32'd0;
        @(posedge clk);
        #1;

        step("in_reset", 1'b1, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
        for (int r = 1; r < 32; r++) begin
            rd($sformatf("rst_r%0d", r), 5'(r), 5'(32 - r));
        end

        step("byp_r5", 1'b0, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0, 5'd0, 5'd5, 1'b0, 5'd0, 1'b0);
        rd("stored_r5", 5'd5, 5'd5);

        step("dual_r7", 1'b0, 2'b11, 5'd7, 32'h11111111, 5'd7, 32'h22222222, 5'd7, 5'd7, 1'b0, 5'd0, 1'b0);
        rd("stored_r7", 5'd7, 5'd7);

        step("zero_wr", 1'b0, 2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
        rd("zero_rd", 5'd0, 5'd0);

        step("iss_r9", 1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd9, 5'd9, 1'b1, 5'd9, 1'b0);
        rd("busy_r9", 5'd9, 5'd9);
        step("wr_iss_r9", 1'b0, 2'b01, 5'd9, 32'hAAAA0001, 5'd0, 32'd0, 5'd9, 5'd9, 1'b1, 5'd9, 1'b0);
        rd("still_r9", 5'd9, 5'd9);
        step("wr_r9", 1'b0, 2'b10, 5'd0, 32'd0, 5'd9, 32'h55550002, 5'd9, 5'd9, 1'b0, 5'd0, 1'b0);
        rd("clear_r9", 5'd9, 5'd9);

        step("iss_r3", 1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd3, 5'd4, 1'b1, 5'd3, 1'b0);
        step("iss_r4", 1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd3, 5'd4, 1'b1, 5'd4, 1'b0);
        step("iss_r6", 1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd4, 5'd6, 1'b1, 5'd6, 1'b0);
        step("flush",  1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd3, 5'd6, 1'b1, 5'd8, 1'b1);
        rd("post_flush", 5'd8, 5'd3);

        step("wr_r2", 1'b0, 2'b10, 5'd0, 32'd0, 5'd2, 32'h00001234, 5'd2, 5'd1, 1'b1, 5'd2, 1'b0);
        rd("stored_r2", 5'd2, 5'd2);
        step("rst_mid", 1'b1, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd2, 5'd5, 1'b0, 5'd0, 1'b0);
        rd("after_rst", 5'd2, 5'd7);

        for (int i = 0; i < 600; i++) begin
            r_rst = ($urandom_range(0, 99) == 0);
            r_we  = r_rst ? 2'b00 : 2'($urandom_range(0, 3));
            r_wa0 = rnd_addr();
            r_wa1 = rnd_addr();
            r_wd0 = $urandom;
            r_wd1 = $urandom;
            r_ra0 = rnd_addr();
            r_ra1 = rnd_addr();
            r_ie  = ($urandom_range(0, 1) == 1);
            r_ia  = rnd_addr();
            r_fl  = ($urandom_range(0, 19) == 0);
            step($sformatf("rnd%0d", i), r_rst, r_we, r_wa0, r_wd0, r_wa1, r_wd1,
                 r_ra0, r_ra1, r_ie, r_ia, r_fl);
        end

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
        check("queue_drain", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_mp_bypass.md
Name: regfile_mp_bypass

Overview:
Parametrised multi-port register file for the pipelined CPU. It replaces the fixed 2-read/1-write 32x32 file. Adds:
- a second write port
- same-cycle write-to-read bypass
- a per-register busy scoreboard for the hazard unit (set at issue, cleared at writeback, bulk-cleared on flush)

It sits between decode (reads, issue) and writeback (writes).

Parameters:
DATA_W, 32, data width in bits
NUM_REGS, 32, number of architectural registers (power of two, >=2)
ADDR_W, $clog2(NUM_REGS), register address width (derived, not overridden)
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 hardwired to zero, never written, never busy

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  2  write enables; bit 0 = port 0, bit 1 = port 1
wr_addr  in  2*ADDR_W  write addresses, port p at [p*ADDR_W +: ADDR_W]
wr_data  in  2*DATA_W  write data, port p at [p*DATA_W +: DATA_W]
rd_addr  in  NUM_RD*ADDR_W  read addresses, packed per port
rd_data  out  NUM_RD*DATA_W  read data, combinational, packed per port
rd_busy  out  NUM_RD  busy flag of the addressed register, combinational
issue_en  in  1  mark issue_addr busy (a producer has been issued)
issue_addr  in  ADDR_W  destination register being issued
flush  in  1  synchronous clear of all busy bits
busy_vec  out  NUM_REGS  registered busy bitmap, for debug/hazard unit

Behaviour:
- Reset (rst_n low, async): all registers = 0; all busy bits = 0. Hence rd_data = 0, rd_busy = 0, busy_vec = 0 during and right after reset.
- Write: on a rising edge with wr_en[p]=1, reg[wr_addr p] <= wr_data p.
  - Both ports, same address: port 1 wins.
  - ZERO_REG=1 and address 0: write ignored.
- Read (combinational, zero latency):
  - ZERO_REG=1 and address 0: rd_data = 0.
  - Else if wr_en[1] and wr_addr1 == rd_addr: rd_data = wr_data1 (bypass).
  - Else if wr_en[0] and wr_addr0 == rd_addr: rd_data = wr_data0 (bypass).
  - Else rd_data = stored value.
  - Bypass priority matches write priority, so the read value equals the value stored after the edge.
- Scoreboard, next-state per register r, evaluated in this order:
  1. flush=1: busy[r] <= 0. This overrides issue and writes in the same cycle.
  2. Else issue_en and issue_addr == r: busy[r] <= 1. Issue wins over a same-cycle write clear (new producer in flight).
  3. Else any wr_en[p] with wr_addr p == r: busy[r] <= 0.
  4. Else hold.
  - ZERO_REG=1: busy[0] is constant 0; issue to register 0 is ignored.
- rd_busy:
  - Equals busy[rd_addr] with same-cycle write clears forwarded: a register being written this cycle reads not-busy.
  - A same-cycle issue is NOT forwarded; it becomes visible next cycle.
  - ZERO_REG=1 and address 0: rd_busy = 0.
- busy_vec is the raw registered bitmap, with no forwarding.
- Asynchronous reset mid-operation: all state cleared immediately. Pending writes on that edge are lost.
- Out-of-range addresses are impossible: NUM_REGS is a power of two.

Decomposition:
- Shared package regfile_pkg holds:
  - localparams: default DATA_W/NUM_REGS
  - function clog2 for ADDR_W
  - constant WR_PORTS = 2
- One sub-module is natural: regfile_scoreboard, containing the busy bitmap, flush/issue/clear priority and the rd_busy forwarding.
- The storage array and bypass muxes stay in the top module.

Test Plan:
- Reset, then read r1..r31 on both ports -> rd_data = 0x00000000, rd_busy = 0, busy_vec = 0.
- Write r5 = 0xDEADBEEF via port 0; read r5 on read port 1 in the same cycle -> 0xDEADBEEF (bypass); next cycle, with no write -> 0xDEADBEEF (stored).
- Both ports write r7 (port 0 = 0x11111111, port 1 = 0x22222222) -> same-cycle read = 0x22222222; stored value afterwards = 0x22222222.
- Write r0 = 0xFFFFFFFF with ZERO_REG=1, issue r0 -> rd_data(r0) = 0, rd_busy = 0, busy_vec[0] = 0.
- Issue r9; next cycle rd_busy(r9) = 1. Write r9 while issuing r9 again -> busy_vec[9] stays 1. Write r9 with no issue -> same-cycle rd_busy = 0; busy_vec[9] = 0 the next cycle.
- Issue r3, r4, r6 over three cycles, then flush asserted together with issue r8 -> busy_vec = 0 next cycle. Assert rst_n low mid-sequence after writing r2 = 0x1234 -> r2 reads 0 immediately.
